// File: rtl/park_transform_if.sv
// Sample/result handshake bundle for park_transform.
// The slave modport is the transform; the master modport is whoever feeds it samples.
interface park_transform_if #(
  parameter int unsigned D_WIDTH = 32
);
  logic signed [D_WIDTH-1:0] alpha;
  logic signed [D_WIDTH-1:0] beta;
  logic signed [D_WIDTH-1:0] sin;
  logic signed [D_WIDTH-1:0] cos;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [D_WIDTH-1:0] d;
  logic signed [D_WIDTH-1:0] q;
  logic                      sat;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output alpha, beta, sin, cos, in_valid, out_ready,
    input  in_ready, d, q, sat, out_valid
  );

  modport slave (
    input  alpha, beta, sin, cos, in_valid, out_ready,
    output in_ready, d, q, sat, out_valid
  );
endinterface

// File: rtl/park_transform.sv
// Park transform (alpha/beta -> d/q) built around one signed multiplier that is
// time-shared across four cycles, with saturating output and valid/ready handshakes.
module park_transform #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned Q_BITS  = 10
) (
  input logic              clk,
  input logic              rstb,
  park_transform_if.slave  bus
);
  localparam int unsigned AW = 2 * D_WIDTH + 1;

  typedef enum logic [2:0] {StIdle, StMul0, StMul1, StMul2, StMul3, StOut} state_e;

  state_e state_q, state_d;

  logic signed [D_WIDTH-1:0]   alpha_q, beta_q, sin_q, cos_q;
  logic signed [D_WIDTH-1:0]   op_a, op_b;
  logic signed [2*D_WIDTH-1:0] prod;
  logic signed [AW-1:0]        prod_ext, acc_q_fin;
  logic signed [AW-1:0]        acc_d_q, acc_d_d, acc_q_q, acc_q_d;
  logic signed [D_WIDTH-1:0]   d_q, d_d, q_q, q_d;
  logic                        sat_q, sat_d, capture;
  logic [D_WIDTH:0]            clamp_d, clamp_q;

  // Returns {overflow, clamped value} of v >>> Q_BITS.
  function automatic logic [D_WIDTH:0] shift_clamp(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s, max_v, min_v;
    s     = v >>> Q_BITS;
    max_v = {{(AW - D_WIDTH + 1){1'b0}}, {(D_WIDTH - 1){1'b1}}};
    min_v = {{(AW - D_WIDTH + 1){1'b1}}, {(D_WIDTH - 1){1'b0}}};
    if (s > max_v) begin
      shift_clamp = {1'b1, max_v[D_WIDTH-1:0]};
    end else if (s < min_v) begin
      shift_clamp = {1'b1, min_v[D_WIDTH-1:0]};
    end else begin
      shift_clamp = {1'b0, s[D_WIDTH-1:0]};
    end
  endfunction

  always_comb begin
    op_a = alpha_q;
    op_b = cos_q;
    unique case (state_q)
      StMul1:  begin op_a = beta_q;  op_b = sin_q; end
      StMul2:  begin op_a = beta_q;  op_b = cos_q; end
      StMul3:  begin op_a = alpha_q; op_b = sin_q; end
      default: begin op_a = alpha_q; op_b = cos_q; end
    endcase
  end

  assign prod      = op_a * op_b;
  assign prod_ext  = {prod[2*D_WIDTH-1], prod};
  assign acc_q_fin = acc_q_q - prod_ext;
  assign clamp_d   = shift_clamp(acc_d_q);
  assign clamp_q   = shift_clamp(acc_q_fin);

  always_comb begin
    state_d = state_q;
    acc_d_d = acc_d_q;
    acc_q_d = acc_q_q;
    d_d     = d_q;
    q_d     = q_q;
    sat_d   = sat_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          state_d = StMul0;
        end
      end
      StMul0: begin
        acc_d_d = prod_ext;
        state_d = StMul1;
      end
      StMul1: begin
        acc_d_d = acc_d_q + prod_ext;
        state_d = StMul2;
      end
      StMul2: begin
        acc_q_d = prod_ext;
        state_d = StMul3;
      end
      StMul3: begin
        acc_q_d = acc_q_fin;
        d_d     = clamp_d[D_WIDTH-1:0];
        q_d     = clamp_q[D_WIDTH-1:0];
        sat_d   = clamp_d[D_WIDTH] | clamp_q[D_WIDTH];
        state_d = StOut;
      end
      StOut: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      alpha_q <= '0;
      beta_q  <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      acc_d_q <= '0;
      acc_q_q <= '0;
      d_q     <= '0;
      q_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_d_q <= acc_d_d;
      acc_q_q <= acc_q_d;
      d_q     <= d_d;
      q_q     <= q_d;
      sat_q   <= sat_d;
      if (capture) begin
        alpha_q <= bus.alpha;
        beta_q  <= bus.beta;
        sin_q   <= bus.sin;
        cos_q   <= bus.cos;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut);
  assign bus.d         = d_q;
  assign bus.q         = q_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_park_transform.sv
// Directed-vector bench for park_transform with hand-computed expected results.
module tb_park_transform;
  logic clk;
  logic rstb;
  int   vectors = 0;
  int   errors  = 0;

  park_transform_if #(.D_WIDTH(32)) bus ();

  park_transform #(
    .D_WIDTH(32),
    .Q_BITS (10)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic signed [31:0] a, input logic signed [31:0] b,
                       input logic signed [31:0] s, input logic signed [31:0] c);
    bus.alpha = a;
    bus.beta  = b;
    bus.sin   = s;
    bus.cos   = c;
  endtask

  // Capture one sample, check latency and result, then hand it off.
  task automatic run(input string tag,
                     input logic signed [31:0] a, input logic signed [31:0] b,
                     input logic signed [31:0] s, input logic signed [31:0] c,
                     input logic signed [31:0] ed, input logic signed [31:0] eq,
                     input logic es);
    int n;
    @(negedge clk);
    drive(a, b, s, c);
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'sd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drive(32'sd0, 32'sd0, 32'sd0, 32'sd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'sd4);
    chk({tag, "_d"}, bus.d, ed);
    chk({tag, "_q"}, bus.q, eq);
    chk({tag, "_sat"}, 32'(bus.sat), 32'(es));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ov_fall"}, 32'(bus.out_valid), 32'sd0);
    chk({tag, "_d_hold"}, bus.d, ed);
  endtask

  initial begin
    rstb          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(32'sd0, 32'sd0, 32'sd0, 32'sd0);
    #12;
    chk("rst_d", bus.d, 32'sd0);
    chk("rst_q", bus.q, 32'sd0);
    chk("rst_sat", 32'(bus.sat), 32'sd0);
    chk("rst_ov", 32'(bus.out_valid), 32'sd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'sd1);
    @(negedge clk);
    rstb = 1'b1;

    run("ident", 32'sd100, 32'sd50, 32'sd0, 32'sd1024, 32'sd100, 32'sd50, 1'b0);
    run("deg90", 32'sd100, 32'sd50, 32'sd1024, 32'sd0, 32'sd50, -32'sd100, 1'b0);
    run("floor", -32'sd1, 32'sd0, 32'sd0, 32'sd512, -32'sd1, 32'sd0, 1'b0);
    run("deg30", 32'sd1000, -32'sd2000, 32'sd512, 32'sd887, -32'sd134, -32'sd2233, 1'b0);
    run("sat_pos", 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff,
        32'sh7fffffff, 32'sd0, 1'b1);
    run("sat_neg", 32'sh80000000, 32'sd0, 32'sd0, 32'sh7fffffff,
        32'sh80000000, 32'sd0, 1'b1);

    // Backpressure: hold in OUT while inputs churn with in_valid high.
    @(negedge clk);
    drive(32'sd7, -32'sd3, 32'sd0, 32'sd1024);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_ov", 32'(bus.out_valid), 32'sd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(32'(i * 37 + 5), -32'(i * 11), 32'sd1024, 32'sd0);
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_d", bus.d, 32'sd7);
      chk("bp_q", bus.q, -32'sd3);
      chk("bp_sat", 32'(bus.sat), 32'sd0);
      chk("bp_ov_hold", 32'(bus.out_valid), 32'sd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'sd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_release_ov", 32'(bus.out_valid), 32'sd0);
    chk("bp_release_idle", 32'(bus.in_ready), 32'sd1);
    chk("bp_release_d", bus.d, 32'sd7);

    // Reset while the multiplier sits in its third step.
    @(negedge clk);
    drive(32'sd300, 32'sd200, 32'sd0, 32'sd1024);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    chk("mid_rst_d", bus.d, 32'sd0);
    chk("mid_rst_q", bus.q, 32'sd0);
    chk("mid_rst_ov", 32'(bus.out_valid), 32'sd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'sd1);
    @(negedge clk);
    rstb = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_result", 32'(bus.out_valid), 32'sd0);
    run("post_rst", 32'sd100, 32'sd50, 32'sd0, 32'sd1024, 32'sd100, 32'sd50, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
